// File: rtl/design_select_mux.sv
//------------------------------------------------------------------------------
// design_select_mux : four design slots on shared I/O, one selected onto io_out
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module design_select_mux #(
  parameter int IO_WIDTH = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          des_sel,
  input  logic                hold_reset,
  input  logic                sync_inputs,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out
);

  localparam logic [5:0] C_SLOT_CNT = 6'd2;
  localparam logic [5:0] C_SLOT_SR  = 6'd3;

  logic [IO_WIDTH-1:0] sync1_q, sync1_d;
  logic [IO_WIDTH-1:0] sync2_q, sync2_d;
  logic [IO_WIDTH-1:0] cnt_q, cnt_d;
  logic [IO_WIDTH-1:0] sr_q, sr_d;
  logic [IO_WIDTH-1:0] din;
  logic                cnt_rst;
  logic                sr_rst;

  // Synchronizer runs regardless of sync_inputs so switching it on never
  // exposes stale data older than two cycles.
  always_comb begin
    sync1_d = io_in;
    sync2_d = sync1_q;
    din     = sync_inputs ? sync2_q : io_in;
  end

  always_comb begin
    cnt_rst = reset | (hold_reset & (des_sel != C_SLOT_CNT));
    sr_rst  = reset | (hold_reset & (des_sel != C_SLOT_SR));
  end

  // Counter wraps naturally at the bus width; din[1] picks the direction.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_rst) begin
      cnt_d = '0;
    end else if (din[0]) begin
      cnt_d = din[1] ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  always_comb begin
    sr_d = {sr_q[IO_WIDTH-2:0], din[0]};
    if (sr_rst) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
    cnt_q <= cnt_d;
    sr_q  <= sr_d;
  end

  always_comb begin
    io_out = '0;
    case (des_sel)
      6'd0:    io_out = din;
      6'd1:    io_out = ~din;
      6'd2:    io_out = cnt_q;
      6'd3:    io_out = sr_q;
      default: io_out = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_design_select_mux.sv
//------------------------------------------------------------------------------
// tb_design_select_mux : directed self-checking bench for design_select_mux
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_design_select_mux;

  logic        clock;
  logic        reset;
  logic [5:0]  des_sel;
  logic        hold_reset;
  logic        sync_inputs;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int errors;
  int checks;

  design_select_mux #(.IO_WIDTH(12)) dut (
    .clock       (clock),
    .reset       (reset),
    .des_sel     (des_sel),
    .hold_reset  (hold_reset),
    .sync_inputs (sync_inputs),
    .io_in       (io_in),
    .io_out      (io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    checks++;
    if (io_out !== exp) begin
      errors++;
      $display("FAIL %s: io_out=%0d (0x%03h) expected=%0d (0x%03h)", name, io_out, io_out, exp, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; des_sel = 6'd2; hold_reset = 1'b1; sync_inputs = 1'b0; io_in = 12'd1;
    step(5);
    check("reset_cnt_zero", 12'd0);
    des_sel = 6'd3; #1;
    check("reset_sr_zero", 12'd0);
    des_sel = 6'd0; io_in = 12'h3C5; #1;
    check("reset_loopback_live", 12'h3C5);
    des_sel = 6'd2; io_in = 12'd1;
  endtask

  task automatic test_count_up();
    reset = 1'b0;
    step(1);
    check("count_up_first", 12'd1);
    step(99);
    check("count_up_100", 12'd100);
  endtask

  task automatic test_count_down();
    io_in = 12'd3;
    step(1);
    check("count_down_99", 12'd99);
    step(19);
    check("count_down_80", 12'd80);
    io_in = 12'hFFC;
    step(3);
    check("count_hold_upper_ignored", 12'd80);
  endtask

  task automatic test_wrap();
    io_in = 12'd3;
    step(80);
    check("down_to_zero", 12'd0);
    step(1);
    check("wrap_0_minus_1", 12'd4095);
    io_in = 12'd1;
    step(1);
    check("wrap_4095_plus_1", 12'd0);
  endtask

  task automatic test_reset_mid_count();
    io_in = 12'd1;
    step(3);
    check("mid_count_3", 12'd3);
    reset = 1'b1;
    step(1);
    check("reset_dominates", 12'd0);
    reset = 1'b0;
    step(1);
    check("resume_from_0", 12'd1);
  endtask

  task automatic test_shift();
    logic [3:0] pat;
    pat = 4'b1011;
    des_sel = 6'd3; hold_reset = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      io_in = {11'h2AA, pat[i]};
      step(1);
    end
    check("shift_1011", 12'h00B);
    hold_reset = 1'b0; des_sel = 6'd0; io_in = 12'h005; #1;
    check("loopback_005", 12'h005);
    step(2);
    des_sel = 6'd3; #1;
    check("shift_runs_deselected", 12'h02F);
    hold_reset = 1'b1; des_sel = 6'd0;
    step(1);
    des_sel = 6'd3; #1;
    check("shift_held_when_deselected", 12'h000);
  endtask

  task automatic test_hold_reset_reselect();
    des_sel = 6'd2; hold_reset = 1'b1; reset = 1'b1; io_in = 12'd1;
    step(1);
    reset = 1'b0;
    step(3);
    check("pre_switch_cnt_3", 12'd3);
    des_sel = 6'd0; io_in = 12'hA51; #1;
    check("slot0_passthrough", 12'hA51);
    step(1);
    des_sel = 6'd2; #1;
    check("cnt_cleared_on_return", 12'd0);
    io_in = 12'd1;
    step(1);
    check("cnt_restart_1", 12'd1);
  endtask

  task automatic test_empty_and_invert();
    des_sel = 6'd5; io_in = 12'hFFF; #1;
    check("empty_slot5_fff", 12'd0);
    io_in = 12'h123; #1;
    check("empty_slot5_123", 12'd0);
    des_sel = 6'd63; #1;
    check("empty_slot63", 12'd0);
    des_sel = 6'd1; io_in = 12'h0F0; #1;
    check("invert_0f0", 12'hF0F);
  endtask

  task automatic test_sync_latency();
    des_sel = 6'd2; hold_reset = 1'b1; sync_inputs = 1'b1; reset = 1'b1; io_in = 12'd0;
    step(2);
    reset = 1'b0; io_in = 12'd1;
    step(1);
    check("sync_edge1", 12'd0);
    step(1);
    check("sync_edge2", 12'd0);
    step(1);
    check("sync_edge3", 12'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; des_sel = 6'd0; hold_reset = 1'b0; sync_inputs = 1'b0; io_in = 12'd0;
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_wrap();
    test_reset_mid_count();
    test_shift();
    test_hold_reset_reselect();
    test_empty_and_invert();
    test_sync_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/design_select_mux.md
DESIGN_SELECT_MUX -- requirements
Module: design_select_mux

Interface
REQ-001 Parameter IO_WIDTH, default 12: width of the shared design I/O buses; all behaviour below is stated for 12.
REQ-002 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port des_sel, input, 6: design-slot select; slots 0-3 populated, 4-63 empty.
REQ-005 Port hold_reset, input, 1: 1 = every non-selected slot is held in reset.
REQ-006 Port sync_inputs, input, 1: 1 = io_in passes through a 2-flop synchronizer before reaching the slots.
REQ-007 Port io_in, input, 12: design inputs, shared by all slots.
REQ-008 Port io_out, output, 12: output of the selected slot.

Function
REQ-009 Slot input bus din SHALL be io_in directly when sync_inputs=0, and the output of a 2-stage io_in register chain when sync_inputs=1 (2-cycle latency).
REQ-010 Synchronizer flops SHALL clock continuously, independent of sync_inputs, and SHALL reset to 0.
REQ-011 Slot k internal reset SHALL be reset OR (hold_reset AND des_sel!=k).
REQ-012 io_out SHALL be a combinational mux of the slot outputs on des_sel; des_sel 4-63 -> io_out=0.
REQ-013 Slot 0 (loopback): out = din, combinational.
REQ-014 Slot 1 (invert): out = ~din, combinational.
REQ-015 Slot 2 (counter): 12-bit register cnt, out = cnt.
REQ-016 Counter: din[0]=0 -> hold; din[0]=1, din[1]=0 -> cnt+1; din[0]=1, din[1]=1 -> cnt-1; din[11:2] ignored.
REQ-017 Counter arithmetic SHALL be modulo 4096: 4095+1 -> 0, 0-1 -> 4095, with no flag or stall.
REQ-018 Slot 3 (shift register): 12-bit sr, out = sr; each cycle sr <= {sr[10:0], din[0]}.
REQ-019 With hold_reset=0, non-selected stateful slots SHALL keep running on din.
REQ-020 A change of des_sel SHALL take effect on io_out in the same cycle, with no glitch-filtering register.
REQ-021 A slot deselected under hold_reset=1 SHALL hold 0 from the next edge and SHALL restart from 0 when reselected.

Reset
REQ-022 While reset=1 at a rising edge: cnt, sr and both synchronizer stages SHALL load 0.
REQ-023 After reset, io_out SHALL be 0 for slots 2 and 3 (slots 0 and 1 follow din combinationally).
REQ-024 Reset SHALL dominate count enable when both are asserted in the same cycle.
REQ-025 Reset asserted mid-count SHALL clear cnt at that edge; counting SHALL resume from 0 on the first edge with reset=0.
REQ-026 No asynchronous reset path SHALL exist.

Verification
REQ-027 Scenario 1: des_sel=2, sync_inputs=0, hold_reset=1, io_in=1, reset for 5 cycles, then release -> io_out=1 after the first edge, 100 after 100 edges.
REQ-028 Scenario 2: continue from 100, set io_in=3 -> io_out decrements by 1 per edge, reaching 80 after 20 edges.
REQ-029 Scenario 3: cnt=4095, io_in=1 -> 0 after 1 edge; cnt=0, io_in=3 -> 4095 after 1 edge.
REQ-030 Scenario 4: sync_inputs=1, counter at 0, io_in 0->1 -> io_out still 0 for 2 edges, 1 at the 3rd edge.
REQ-031 Scenario 5: des_sel 2->0 with hold_reset=1, then back to 2 -> io_out=io_in while at 0; counter restarts from 0 on return.
REQ-032 Scenario 6: des_sel=5 -> io_out=0 for any io_in; des_sel=1, io_in=12'h0F0 -> io_out=12'hF0F.
